// File: rtl/grf_hazard_ctrl.sv
// rtl/grf_hazard_ctrl.sv - GRF write-back tracking, operand forwarding and decode stall control
module grf_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic        rs_need,
  input  logic        rt_need,
  input  logic [31:0] grf_r1,
  input  logic [31:0] grf_r2,
  input  logic        issue_valid,
  input  logic        issue_we,
  input  logic [4:0]  issue_a3,
  input  logic [1:0]  issue_tnew,
  input  logic [31:0] issue_pc,
  input  logic [31:0] e_wd,
  input  logic [31:0] m_wd,
  input  logic [31:0] w_wd,
  output logic [31:0] rs_val,
  output logic [31:0] rt_val,
  output logic        stall,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc
);

  logic        e_valid, m_valid, w_valid;
  logic [4:0]  e_a3, m_a3, w_a3;
  logic [1:0]  e_tnew, m_tnew, w_tnew;
  logic [31:0] e_pc, m_pc, w_pc;

  logic rs_pend, rt_pend;
  logic issue_ok;

  // tnew counts stages remaining, so it drops by one on every stage advance
  function automatic logic [1:0] dec_tnew(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Only real register writers occupy a slot; a stalled issue becomes a bubble
  assign issue_ok = !stall && issue_valid && issue_we && (issue_a3 != 5'd0);

  // Slot pipeline E -> M -> W; a load (tnew=2) reaches W with tnew=0
  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid <= 1'b0;  e_a3 <= 5'd0;  e_tnew <= 2'd0;  e_pc <= 32'd0;
      m_valid <= 1'b0;  m_a3 <= 5'd0;  m_tnew <= 2'd0;  m_pc <= 32'd0;
      w_valid <= 1'b0;  w_a3 <= 5'd0;  w_tnew <= 2'd0;  w_pc <= 32'd0;
    end else begin
      w_valid <= m_valid;
      w_a3    <= m_a3;
      w_tnew  <= dec_tnew(m_tnew);
      w_pc    <= m_pc;
      m_valid <= e_valid;
      m_a3    <= e_a3;
      m_tnew  <= dec_tnew(e_tnew);
      m_pc    <= e_pc;
      e_valid <= issue_ok;
      e_a3    <= issue_a3;
      e_tnew  <= issue_tnew;
      e_pc    <= issue_pc;
    end
  end

  // rs operand: newest matching producer wins, even when it is not ready yet
  always_comb begin
    rs_val  = grf_r1;
    rs_pend = 1'b0;
    if (rs_addr == 5'd0) begin
      rs_val = 32'd0;
    end else if (e_valid && e_a3 == rs_addr) begin
      if (e_tnew == 2'd0) rs_val = e_wd;
      else                rs_pend = 1'b1;
    end else if (m_valid && m_a3 == rs_addr) begin
      if (m_tnew == 2'd0) rs_val = m_wd;
      else                rs_pend = 1'b1;
    end else if (w_valid && w_a3 == rs_addr) begin
      if (w_tnew == 2'd0) rs_val = w_wd;
      else                rs_pend = 1'b1;
    end
  end

  // rt operand: same resolution as rs against the second read port
  always_comb begin
    rt_val  = grf_r2;
    rt_pend = 1'b0;
    if (rt_addr == 5'd0) begin
      rt_val = 32'd0;
    end else if (e_valid && e_a3 == rt_addr) begin
      if (e_tnew == 2'd0) rt_val = e_wd;
      else                rt_pend = 1'b1;
    end else if (m_valid && m_a3 == rt_addr) begin
      if (m_tnew == 2'd0) rt_val = m_wd;
      else                rt_pend = 1'b1;
    end else if (w_valid && w_a3 == rt_addr) begin
      if (w_tnew == 2'd0) rt_val = w_wd;
      else                rt_pend = 1'b1;
    end
  end

  assign stall = (rs_need && rs_pend) || (rt_need && rt_pend);

  // W slot drives the GRF write port; W never holds $0 because such issues are dropped
  assign grf_we = w_valid;
  assign grf_a3 = w_a3;
  assign grf_wd = w_wd;
  assign grf_pc = w_pc;

endmodule
